// File: rtl/tl_ul_pkg.sv
// Shared TileLink-UL definitions: opcodes, default field widths, channel structs
// and width helpers used to flatten channel fields into FIFO words.
package tl_ul_pkg;

  localparam logic [2:0] PutFullData    = 3'd0;
  localparam logic [2:0] PutPartialData = 3'd1;
  localparam logic [2:0] Get            = 3'd4;
  localparam logic [2:0] AccessAck      = 3'd0;
  localparam logic [2:0] AccessAckData  = 3'd1;

  localparam int TL_OPCODE_W  = 3;
  localparam int TL_A_PARAM_W = 3;
  localparam int TL_D_PARAM_W = 2;
  localparam int TL_ADDR_W    = 30;
  localparam int TL_DATA_W    = 32;
  localparam int TL_SIZE_W    = 3;
  localparam int TL_SOURCE_W  = 1;

  typedef struct packed {
    logic [TL_OPCODE_W-1:0]  opcode;
    logic [TL_A_PARAM_W-1:0] param;
    logic [TL_SIZE_W-1:0]    size;
    logic [TL_SOURCE_W-1:0]  source;
    logic [TL_ADDR_W-1:0]    address;
    logic [TL_DATA_W/8-1:0]  mask;
    logic [TL_DATA_W-1:0]    data;
    logic                    corrupt;
  } tl_a_fields_t;

  typedef struct packed {
    logic [TL_OPCODE_W-1:0]  opcode;
    logic [TL_D_PARAM_W-1:0] param;
    logic [TL_SIZE_W-1:0]    size;
    logic [TL_SOURCE_W-1:0]  source;
    logic                    sink;
    logic                    denied;
    logic [TL_DATA_W-1:0]    data;
    logic                    corrupt;
  } tl_d_fields_t;

  function automatic int tl_a_width(int addr_w, int data_w, int size_w, int source_w);
    return TL_OPCODE_W + TL_A_PARAM_W + size_w + source_w + addr_w + data_w / 8 + data_w + 1;
  endfunction

  function automatic int tl_d_width(int data_w, int size_w, int source_w);
    return TL_OPCODE_W + TL_D_PARAM_W + size_w + source_w + 3 + data_w;
  endfunction

  function automatic int tl_cnt_w(int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

  function automatic int tl_ptr_w(int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/tl_ul_fifo.sv
// Single-clock FIFO with optional pipe (accept-when-full-and-draining) and flow
// (empty bypass) modes; DEPTH=0 is a wire. Occupancy ports need TL_UL_CHAN_BUFFER_OCC_EN.
module tl_ul_fifo
  import tl_ul_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int PIPE  = 0,
  parameter int FLOW  = 0,
  localparam int PTR_W = tl_ptr_w(DEPTH),
  localparam int CNT_W = tl_cnt_w(DEPTH)
) (
  input  logic             clock,
  input  logic             reset_n,
`ifdef TL_UL_CHAN_BUFFER_OCC_EN
  output logic [CNT_W-1:0] o_count,
  output logic [CNT_W-1:0] o_hwm,
`endif
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_in_data,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out_data
);

  if (DEPTH == 0) begin : g_wire
    logic w_unused_clk_rst;
    assign w_unused_clk_rst = clock ^ reset_n;
    assign o_out_valid = i_in_valid;
    assign o_in_ready  = i_out_ready;
    assign o_out_data  = i_in_data;
`ifdef TL_UL_CHAN_BUFFER_OCC_EN
    assign o_count = '0;
    assign o_hwm   = '0;
`endif
  end else begin : g_buf
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr, r_wr_ptr;
    logic [CNT_W-1:0] r_count, w_count_nxt;
    logic w_full, w_empty, w_bypass, w_in_ready, w_out_valid;
    logic w_enq, w_deq, w_push, w_pop;

    assign w_full      = (r_count == CNT_W'(DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_bypass    = (FLOW != 0) && w_empty;
    // Handshakes are held low during reset regardless of mode.
    assign w_in_ready  = reset_n && (!w_full || ((PIPE != 0) && i_out_ready));
    assign w_out_valid = reset_n && (!w_empty || ((FLOW != 0) && i_in_valid));
    assign w_enq       = i_in_valid && w_in_ready;
    assign w_deq       = w_out_valid && i_out_ready;
    // A bypassed beat that leaves immediately never touches storage.
    assign w_push      = w_enq && !(w_bypass && i_out_ready);
    assign w_pop       = w_deq && !w_bypass;

    assign o_in_ready  = w_in_ready;
    assign o_out_valid = w_out_valid;
    assign o_out_data  = w_bypass ? i_in_data : r_mem[r_rd_ptr];

    always_comb begin
      w_count_nxt = r_count;
      if (w_push && !w_pop)      w_count_nxt = r_count + CNT_W'(1);
      else if (w_pop && !w_push) w_count_nxt = r_count - CNT_W'(1);
    end

    always_ff @(posedge clock) begin
      if (!reset_n) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
        for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
        r_count <= w_count_nxt;
        if (w_push) begin
          r_mem[r_wr_ptr] <= i_in_data;
          r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
        end
        if (w_pop)
          r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
      end
    end

`ifdef TL_UL_CHAN_BUFFER_OCC_EN
    logic [CNT_W-1:0] r_hwm;
    always_ff @(posedge clock) begin
      if (!reset_n)                  r_hwm <= '0;
      else if (w_count_nxt > r_hwm) r_hwm <= w_count_nxt;
    end
    assign o_count = r_count;
    assign o_hwm   = r_hwm;
`endif
  end

endmodule

// File: rtl/tl_ul_chan_buffer.sv
// TileLink-UL A/D channel buffer between an upstream master (s_*) and downstream slave (m_*).
// Define TL_UL_CHAN_BUFFER_OCC_EN to expose per-channel occupancy and high-water marks.
module tl_ul_chan_buffer
  import tl_ul_pkg::*;
#(
  parameter int ADDR_W   = 30,
  parameter int DATA_W   = 32,
  parameter int SIZE_W   = 3,
  parameter int SOURCE_W = 1,
  parameter int A_DEPTH  = 2,
  parameter int D_DEPTH  = 2,
  parameter int A_PIPE   = 0,
  parameter int A_FLOW   = 0,
  parameter int D_PIPE   = 0,
  parameter int D_FLOW   = 0,
  localparam int A_W     = tl_a_width(ADDR_W, DATA_W, SIZE_W, SOURCE_W),
  localparam int D_W     = tl_d_width(DATA_W, SIZE_W, SOURCE_W),
  localparam int A_CNT_W = tl_cnt_w(A_DEPTH),
  localparam int D_CNT_W = tl_cnt_w(D_DEPTH)
) (
`ifdef TL_UL_CHAN_BUFFER_OCC_EN
  output logic [A_CNT_W-1:0]  a_occ,
  output logic [A_CNT_W-1:0]  a_hwm,
  output logic [D_CNT_W-1:0]  d_occ,
  output logic [D_CNT_W-1:0]  d_hwm,
`endif
  input  logic                clock,
  input  logic                reset_n,
  input  logic                s_a_valid,
  output logic                s_a_ready,
  input  logic [2:0]          s_a_opcode,
  input  logic [2:0]          s_a_param,
  input  logic [SIZE_W-1:0]   s_a_size,
  input  logic [SOURCE_W-1:0] s_a_source,
  input  logic [ADDR_W-1:0]   s_a_address,
  input  logic [DATA_W/8-1:0] s_a_mask,
  input  logic [DATA_W-1:0]   s_a_data,
  input  logic                s_a_corrupt,
  output logic                m_a_valid,
  input  logic                m_a_ready,
  output logic [2:0]          m_a_opcode,
  output logic [2:0]          m_a_param,
  output logic [SIZE_W-1:0]   m_a_size,
  output logic [SOURCE_W-1:0] m_a_source,
  output logic [ADDR_W-1:0]   m_a_address,
  output logic [DATA_W/8-1:0] m_a_mask,
  output logic [DATA_W-1:0]   m_a_data,
  output logic                m_a_corrupt,
  input  logic                m_d_valid,
  output logic                m_d_ready,
  input  logic [2:0]          m_d_opcode,
  input  logic [1:0]          m_d_param,
  input  logic [SIZE_W-1:0]   m_d_size,
  input  logic [SOURCE_W-1:0] m_d_source,
  input  logic                m_d_sink,
  input  logic                m_d_denied,
  input  logic [DATA_W-1:0]   m_d_data,
  input  logic                m_d_corrupt,
  output logic                s_d_valid,
  input  logic                s_d_ready,
  output logic [2:0]          s_d_opcode,
  output logic [1:0]          s_d_param,
  output logic [SIZE_W-1:0]   s_d_size,
  output logic [SOURCE_W-1:0] s_d_source,
  output logic                s_d_sink,
  output logic                s_d_denied,
  output logic [DATA_W-1:0]   s_d_data,
  output logic                s_d_corrupt
);

  logic [A_W-1:0] w_a_in, w_a_out;
  logic [D_W-1:0] w_d_in, w_d_out;

  assign w_a_in = {s_a_opcode, s_a_param, s_a_size, s_a_source,
                   s_a_address, s_a_mask, s_a_data, s_a_corrupt};
  assign {m_a_opcode, m_a_param, m_a_size, m_a_source,
          m_a_address, m_a_mask, m_a_data, m_a_corrupt} = w_a_out;

  assign w_d_in = {m_d_opcode, m_d_param, m_d_size, m_d_source,
                   m_d_sink, m_d_denied, m_d_data, m_d_corrupt};
  assign {s_d_opcode, s_d_param, s_d_size, s_d_source,
          s_d_sink, s_d_denied, s_d_data, s_d_corrupt} = w_d_out;

  tl_ul_fifo #(.WIDTH(A_W), .DEPTH(A_DEPTH), .PIPE(A_PIPE), .FLOW(A_FLOW)) u_a_fifo (
    .clock       (clock),
    .reset_n     (reset_n),
`ifdef TL_UL_CHAN_BUFFER_OCC_EN
    .o_count     (a_occ),
    .o_hwm       (a_hwm),
`endif
    .i_in_valid  (s_a_valid),
    .o_in_ready  (s_a_ready),
    .i_in_data   (w_a_in),
    .o_out_valid (m_a_valid),
    .i_out_ready (m_a_ready),
    .o_out_data  (w_a_out)
  );

  tl_ul_fifo #(.WIDTH(D_W), .DEPTH(D_DEPTH), .PIPE(D_PIPE), .FLOW(D_FLOW)) u_d_fifo (
    .clock       (clock),
    .reset_n     (reset_n),
`ifdef TL_UL_CHAN_BUFFER_OCC_EN
    .o_count     (d_occ),
    .o_hwm       (d_hwm),
`endif
    .i_in_valid  (m_d_valid),
    .o_in_ready  (m_d_ready),
    .i_in_data   (w_d_in),
    .o_out_valid (s_d_valid),
    .i_out_ready (s_d_ready),
    .o_out_data  (w_d_out)
  );

endmodule

// File: tb/tb_tl_ul_chan_buffer.sv
// Directed bench over three buffer configurations sharing one clock and reset:
// [0] A2/D2 flow, [1] A1 pipe/D1, [2] A3/D passthrough.
module tb_tl_ul_chan_buffer;
  import tl_ul_pkg::*;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic        s_a_valid [3], s_a_ready [3], s_a_corrupt [3];
  logic [2:0]  s_a_opcode [3], s_a_param [3], s_a_size [3];
  logic [0:0]  s_a_source [3];
  logic [29:0] s_a_address [3];
  logic [3:0]  s_a_mask [3];
  logic [31:0] s_a_data [3];
  logic        m_a_valid [3], m_a_ready [3], m_a_corrupt [3];
  logic [2:0]  m_a_opcode [3], m_a_param [3], m_a_size [3];
  logic [0:0]  m_a_source [3];
  logic [29:0] m_a_address [3];
  logic [3:0]  m_a_mask [3];
  logic [31:0] m_a_data [3];
  logic        m_d_valid [3], m_d_ready [3], m_d_sink [3], m_d_denied [3], m_d_corrupt [3];
  logic [2:0]  m_d_opcode [3], m_d_size [3];
  logic [1:0]  m_d_param [3];
  logic [0:0]  m_d_source [3];
  logic [31:0] m_d_data [3];
  logic        s_d_valid [3], s_d_ready [3], s_d_sink [3], s_d_denied [3], s_d_corrupt [3];
  logic [2:0]  s_d_opcode [3], s_d_size [3];
  logic [1:0]  s_d_param [3];
  logic [0:0]  s_d_source [3];
  logic [31:0] s_d_data [3];

  int n_checks = 0;
  int n_fails  = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int AD  = (g == 0) ? 2 : (g == 1) ? 1 : 3;
    localparam int AP  = (g == 1) ? 1 : 0;
    localparam int DD  = (g == 0) ? 2 : (g == 1) ? 1 : 0;
    localparam int DF  = (g == 0) ? 1 : 0;
`ifdef TL_UL_CHAN_BUFFER_OCC_EN
    localparam int ACW = tl_cnt_w(AD);
    localparam int DCW = tl_cnt_w(DD);
    logic [ACW-1:0] w_a_occ, w_a_hwm;
    logic [DCW-1:0] w_d_occ, w_d_hwm;
`endif
    tl_ul_chan_buffer #(
      .A_DEPTH(AD), .D_DEPTH(DD), .A_PIPE(AP), .A_FLOW(0), .D_PIPE(0), .D_FLOW(DF)
    ) u_dut (
`ifdef TL_UL_CHAN_BUFFER_OCC_EN
      .a_occ(w_a_occ), .a_hwm(w_a_hwm), .d_occ(w_d_occ), .d_hwm(w_d_hwm),
`endif
      .clock(clock), .reset_n(reset_n),
      .s_a_valid(s_a_valid[g]), .s_a_ready(s_a_ready[g]), .s_a_opcode(s_a_opcode[g]),
      .s_a_param(s_a_param[g]), .s_a_size(s_a_size[g]), .s_a_source(s_a_source[g]),
      .s_a_address(s_a_address[g]), .s_a_mask(s_a_mask[g]), .s_a_data(s_a_data[g]),
      .s_a_corrupt(s_a_corrupt[g]),
      .m_a_valid(m_a_valid[g]), .m_a_ready(m_a_ready[g]), .m_a_opcode(m_a_opcode[g]),
      .m_a_param(m_a_param[g]), .m_a_size(m_a_size[g]), .m_a_source(m_a_source[g]),
      .m_a_address(m_a_address[g]), .m_a_mask(m_a_mask[g]), .m_a_data(m_a_data[g]),
      .m_a_corrupt(m_a_corrupt[g]),
      .m_d_valid(m_d_valid[g]), .m_d_ready(m_d_ready[g]), .m_d_opcode(m_d_opcode[g]),
      .m_d_param(m_d_param[g]), .m_d_size(m_d_size[g]), .m_d_source(m_d_source[g]),
      .m_d_sink(m_d_sink[g]), .m_d_denied(m_d_denied[g]), .m_d_data(m_d_data[g]),
      .m_d_corrupt(m_d_corrupt[g]),
      .s_d_valid(s_d_valid[g]), .s_d_ready(s_d_ready[g]), .s_d_opcode(s_d_opcode[g]),
      .s_d_param(s_d_param[g]), .s_d_size(s_d_size[g]), .s_d_source(s_d_source[g]),
      .s_d_sink(s_d_sink[g]), .s_d_denied(s_d_denied[g]), .s_d_data(s_d_data[g]),
      .s_d_corrupt(s_d_corrupt[g])
    );
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic init_inputs();
    for (int g = 0; g < 3; g++) begin
      s_a_valid[g] = 0; s_a_opcode[g] = '0; s_a_param[g] = '0; s_a_size[g] = 3'd2;
      s_a_source[g] = '0; s_a_address[g] = '0; s_a_mask[g] = 4'hF; s_a_data[g] = '0;
      s_a_corrupt[g] = 0; m_a_ready[g] = 0;
      m_d_valid[g] = 0; m_d_opcode[g] = '0; m_d_param[g] = '0; m_d_size[g] = 3'd2;
      m_d_source[g] = '0; m_d_sink[g] = 0; m_d_denied[g] = 0; m_d_data[g] = '0;
      m_d_corrupt[g] = 0; s_d_ready[g] = 0;
    end
  endtask

  task automatic test_reset();
    reset_n = 0;
    tick(); tick();
    for (int g = 0; g < 3; g++) begin
      n_checks++;
      if (m_a_valid[g] !== 1'b0) begin
        n_fails++; $display("FAIL reset_m_a_valid[%0d]: got %b expected 0", g, m_a_valid[g]);
      end
      n_checks++;
      if (s_a_ready[g] !== 1'b0) begin
        n_fails++; $display("FAIL reset_s_a_ready[%0d]: got %b expected 0", g, s_a_ready[g]);
      end
    end
    n_checks++;
    if (m_d_ready[0] !== 1'b0) begin
      n_fails++; $display("FAIL reset_m_d_ready: got %b expected 0", m_d_ready[0]);
    end
    reset_n = 1;
    #1;
    n_checks++;
    if (s_a_ready[0] !== 1'b1) begin
      n_fails++; $display("FAIL post_reset_s_a_ready: got %b expected 1", s_a_ready[0]);
    end
    n_checks++;
    if (m_a_address[0] !== 30'h0 || m_a_data[0] !== 32'h0) begin
      n_fails++; $display("FAIL post_reset_payload: got addr %0h data %0h expected 0 0", m_a_address[0], m_a_data[0]);
    end
  endtask

  task automatic test_backpressure();
    m_a_ready[0] = 0;
    s_a_valid[0] = 1; s_a_opcode[0] = Get; s_a_address[0] = 30'h100;
    #1;
    n_checks++;
    if (s_a_ready[0] !== 1'b1 || m_a_valid[0] !== 1'b0) begin
      n_fails++; $display("FAIL bp_first: got ready %b valid %b expected 1 0", s_a_ready[0], m_a_valid[0]);
    end
    tick();
    s_a_address[0] = 30'h104;
    #1;
    n_checks++;
    if (s_a_ready[0] !== 1'b1 || m_a_valid[0] !== 1'b1 || m_a_address[0] !== 30'h100) begin
      n_fails++; $display("FAIL bp_second: got ready %b valid %b addr %0h expected 1 1 100",
                          s_a_ready[0], m_a_valid[0], m_a_address[0]);
    end
    tick();
    s_a_valid[0] = 0;
    #1;
    n_checks++;
    if (s_a_ready[0] !== 1'b0) begin
      n_fails++; $display("FAIL bp_full_ready: got %b expected 0", s_a_ready[0]);
    end
    m_a_ready[0] = 1;
    #1;
    n_checks++;
    if (m_a_valid[0] !== 1'b1 || m_a_address[0] !== 30'h100 || m_a_opcode[0] !== Get) begin
      n_fails++; $display("FAIL bp_out0: got valid %b addr %0h op %0d expected 1 100 4",
                          m_a_valid[0], m_a_address[0], m_a_opcode[0]);
    end
    tick();
    n_checks++;
    if (m_a_valid[0] !== 1'b1 || m_a_address[0] !== 30'h104 || s_a_ready[0] !== 1'b1) begin
      n_fails++; $display("FAIL bp_out1: got valid %b addr %0h ready %b expected 1 104 1",
                          m_a_valid[0], m_a_address[0], s_a_ready[0]);
    end
    tick();
    n_checks++;
    if (m_a_valid[0] !== 1'b0) begin
      n_fails++; $display("FAIL bp_drained: got valid %b expected 0", m_a_valid[0]);
    end
    m_a_ready[0] = 0;
  endtask

  task automatic test_pipe_stream();
    int beats = 0;
    m_a_ready[1] = 1;
    s_a_opcode[1] = PutFullData;
    for (int i = 0; i <= 8; i++) begin
      s_a_valid[1] = (i < 8);
      s_a_data[1]  = i;
      #1;
      if (i < 8) begin
        n_checks++;
        if (s_a_ready[1] !== 1'b1) begin
          n_fails++; $display("FAIL pipe_ready[%0d]: got %b expected 1", i, s_a_ready[1]);
        end
      end
      n_checks++;
      if (i == 0) begin
        if (m_a_valid[1] !== 1'b0) begin
          n_fails++; $display("FAIL pipe_latency: got valid %b expected 0", m_a_valid[1]);
        end
      end else if (m_a_valid[1] !== 1'b1 || m_a_data[1] !== 32'(i - 1) || m_a_opcode[1] !== PutFullData) begin
        n_fails++; $display("FAIL pipe_beat[%0d]: got valid %b data %0d expected 1 %0d",
                            i, m_a_valid[1], m_a_data[1], i - 1);
      end else begin
        beats++;
      end
      tick();
    end
    n_checks++;
    if (m_a_valid[1] !== 1'b0 || beats != 8) begin
      n_fails++; $display("FAIL pipe_total: got valid %b beats %0d expected 0 8", m_a_valid[1], beats);
    end
    m_a_ready[1] = 0;
  endtask

  task automatic test_flow_bypass();
    s_d_ready[0] = 1;
    m_d_valid[0] = 1; m_d_opcode[0] = AccessAckData; m_d_data[0] = 32'hDEADBEEF;
    #1;
    n_checks++;
    if (s_d_valid[0] !== 1'b1 || s_d_data[0] !== 32'hDEADBEEF || s_d_opcode[0] !== AccessAckData
        || m_d_ready[0] !== 1'b1) begin
      n_fails++; $display("FAIL flow_same_cycle: got valid %b data %0h op %0d ready %b expected 1 deadbeef 1 1",
                          s_d_valid[0], s_d_data[0], s_d_opcode[0], m_d_ready[0]);
    end
    tick();
    m_d_valid[0] = 0;
    #1;
    n_checks++;
    if (s_d_valid[0] !== 1'b0) begin
      n_fails++; $display("FAIL flow_no_enq: got valid %b expected 0", s_d_valid[0]);
    end
`ifdef TL_UL_CHAN_BUFFER_OCC_EN
    n_checks++;
    if (g_dut[0].w_d_occ !== 2'd0) begin
      n_fails++; $display("FAIL flow_count: got %0d expected 0", g_dut[0].w_d_occ);
    end
`endif
    // Bypass with a stalled consumer: beat must be captured and re-presented.
    s_d_ready[0] = 0;
    m_d_valid[0] = 1; m_d_data[0] = 32'h11;
    tick();
    m_d_valid[0] = 0; m_d_data[0] = 32'h22;
    #1;
    n_checks++;
    if (s_d_valid[0] !== 1'b1 || s_d_data[0] !== 32'h11) begin
      n_fails++; $display("FAIL flow_captured: got valid %b data %0h expected 1 11", s_d_valid[0], s_d_data[0]);
    end
    s_d_ready[0] = 1;
    tick();
    n_checks++;
    if (s_d_valid[0] !== 1'b0) begin
      n_fails++; $display("FAIL flow_drained: got valid %b expected 0", s_d_valid[0]);
    end
    s_d_ready[0] = 0;
  endtask

  task automatic test_passthrough();
    m_d_valid[2] = 1; m_d_data[2] = 32'h5A5A_0001; m_d_denied[2] = 1; s_d_ready[2] = 0;
    #1;
    n_checks++;
    if (s_d_valid[2] !== 1'b1 || s_d_data[2] !== 32'h5A5A_0001 || s_d_denied[2] !== 1'b1
        || m_d_ready[2] !== 1'b0) begin
      n_fails++; $display("FAIL pass_wire: got valid %b data %0h denied %b ready %b expected 1 5a5a0001 1 0",
                          s_d_valid[2], s_d_data[2], s_d_denied[2], m_d_ready[2]);
    end
    s_d_ready[2] = 1;
    #1;
    n_checks++;
    if (m_d_ready[2] !== 1'b1) begin
      n_fails++; $display("FAIL pass_ready: got %b expected 1", m_d_ready[2]);
    end
    m_d_valid[2] = 0; m_d_denied[2] = 0; s_d_ready[2] = 0;
    tick();
  endtask

  task automatic test_wrap();
    logic [31:0] pat = 32'hFFFF_DED0;
    logic [29:0] q[$];
    int sent = 0, got = 0, cnt = 0;
    bit exp_rdy, exp_vld, enq, deq;
    for (int s = 0; s < 32 && got < 10; s++) begin
      s_a_valid[2]   = (sent < 10);
      s_a_address[2] = 30'h200 + 30'(sent);
      m_a_ready[2]   = pat[s];
      #1;
      exp_rdy = (cnt != 3);
      exp_vld = (cnt != 0);
      n_checks++;
      if (s_a_ready[2] !== exp_rdy || m_a_valid[2] !== exp_vld) begin
        n_fails++; $display("FAIL wrap_hs[%0d]: got ready %b valid %b expected %b %b",
                            s, s_a_ready[2], m_a_valid[2], exp_rdy, exp_vld);
      end
      if (exp_vld) begin
        n_checks++;
        if (m_a_address[2] !== q[0]) begin
          n_fails++; $display("FAIL wrap_order[%0d]: got %0h expected %0h", s, m_a_address[2], q[0]);
        end
      end
      enq = (sent < 10) && exp_rdy;
      deq = exp_vld && pat[s];
      if (deq) begin void'(q.pop_front()); got++; cnt--; end
      if (enq) begin q.push_back(30'h200 + 30'(sent)); sent++; cnt++; end
      tick();
    end
    n_checks++;
    if (got != 10) begin
      n_fails++; $display("FAIL wrap_total: got %0d beats expected 10 within budget", got);
    end
    s_a_valid[2] = 0; m_a_ready[2] = 0;
  endtask

`ifdef TL_UL_CHAN_BUFFER_OCC_EN
  task automatic test_occ();
    s_d_ready[0] = 0;
    m_d_valid[0] = 1; m_d_data[0] = 32'h1;
    tick();
    m_d_data[0] = 32'h2;
    tick();
    m_d_valid[0] = 0;
    #1;
    n_checks++;
    if (g_dut[0].w_d_occ !== 2'd2 || g_dut[0].w_d_hwm !== 2'd2 || m_d_ready[0] !== 1'b0) begin
      n_fails++; $display("FAIL occ_full: got occ %0d hwm %0d ready %b expected 2 2 0",
                          g_dut[0].w_d_occ, g_dut[0].w_d_hwm, m_d_ready[0]);
    end
    s_d_ready[0] = 1;
    tick(); tick();
    n_checks++;
    if (g_dut[0].w_d_occ !== 2'd0 || g_dut[0].w_d_hwm !== 2'd2) begin
      n_fails++; $display("FAIL occ_drained: got occ %0d hwm %0d expected 0 2",
                          g_dut[0].w_d_occ, g_dut[0].w_d_hwm);
    end
    s_d_ready[0] = 0;
    reset_n = 0;
    tick();
    reset_n = 1;
    #1;
    n_checks++;
    if (g_dut[0].w_d_hwm !== 2'd0 || g_dut[0].w_d_occ !== 2'd0) begin
      n_fails++; $display("FAIL occ_reset: got occ %0d hwm %0d expected 0 0",
                          g_dut[0].w_d_occ, g_dut[0].w_d_hwm);
    end
  endtask
`endif

  task automatic test_reset_midflight();
    m_a_ready[0] = 0;
    s_a_valid[0] = 1; s_a_opcode[0] = PutFullData; s_a_address[0] = 30'hA0;
    tick();
    s_a_address[0] = 30'hA4;
    tick();
    s_a_valid[0] = 0;
    reset_n = 0;
    #1;
    n_checks++;
    if (m_a_valid[0] !== 1'b0 || s_a_ready[0] !== 1'b0) begin
      n_fails++; $display("FAIL mid_reset_hs: got valid %b ready %b expected 0 0", m_a_valid[0], s_a_ready[0]);
    end
    tick();
    reset_n = 1;
    m_a_ready[0] = 1;
    #1;
    n_checks++;
    if (s_a_ready[0] !== 1'b1) begin
      n_fails++; $display("FAIL mid_reset_ready: got %b expected 1", s_a_ready[0]);
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (m_a_valid[0] !== 1'b0) begin
        n_fails++; $display("FAIL mid_reset_discard[%0d]: got valid %b addr %0h expected 0",
                            i, m_a_valid[0], m_a_address[0]);
      end
      tick();
    end
    m_a_ready[0] = 0;
  endtask

  initial begin
    init_inputs();
    test_reset();
    test_backpressure();
    test_pipe_stream();
    test_flow_bypass();
    test_passthrough();
    test_wrap();
`ifdef TL_UL_CHAN_BUFFER_OCC_EN
    test_occ();
`endif
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "time limit");
  end

endmodule
